add_scheduler: RTL

Shares one pipelined single-precision adder between NUM_REQ requesters (the CORDIC stages that today own a private adder each). Arbitrates round-robin, issues at most one operation per cycle, tracks each in-flight operation's requester through the adder's fixed latency, and returns each sum to its owner with a one-cycle done pulse. Sits between the stage controllers and a single `add` instance.

---
 rtl/add_scheduler_pkg.sv | 11 +
 rtl/add_scheduler_if.sv | 15 +
 rtl/add_scheduler_rr_arbiter.sv | 27 ++
 rtl/add_scheduler.sv | 114 +++++++++++
 4 files changed

// File: rtl/add_scheduler_pkg.sv
// add_sched_pkg: shared types and default sizes for the add scheduler
package add_sched_pkg;
    localparam int DEF_FLOAT_DATA_WIDTH = 32;
    localparam int DEF_ADD_LATENCY = 5;
    localparam int TAG_ID_W = 3;
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/add_scheduler_if.sv
// add_scheduler_if: requester-side request/grant/completion bus
interface add_scheduler_if #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                  grant;
    logic [NUM_REQ-1:0]                  done;
    logic [FLOAT_DATA_WIDTH-1:0]         result;
    logic                                busy;
    modport master (output req, req_a, req_b, input grant, done, result, busy);
    modport slave (input req, req_a, req_b, output grant, done, result, busy);
endinterface

// File: rtl/add_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [REQ_ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]      win,
    output logic [REQ_ID_WIDTH-1:0] win_id,
    output logic                    valid
);
    int idx;
    always_comb begin
        win = '0;
        win_id = '0;
        valid = 1'b0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                win = NUM_REQ'(1) << idx;
                win_id = REQ_ID_WIDTH'(idx);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_scheduler.sv
// add_scheduler: round-robin sharing of one pipelined adder; ADD_SCHED_PERF_EN adds issue/stall counters
module add_scheduler
    import add_sched_pkg::*;
#(
    parameter int FLOAT_DATA_WIDTH = DEF_FLOAT_DATA_WIDTH,
    parameter int NUM_REQ = 4,
    parameter int REQ_ID_WIDTH = 2,
    parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    add_scheduler_if.slave              bus,
    output logic                        add_aclr,
    output logic                        add_clk_en,
    output logic [FLOAT_DATA_WIDTH-1:0] add_dataa,
    output logic [FLOAT_DATA_WIDTH-1:0] add_datab,
    input  logic [FLOAT_DATA_WIDTH-1:0] add_result,
    output logic [31:0]                 issue_count,
    output logic [31:0]                 stall_count
);
    logic [NUM_REQ-1:0]          win;
    logic [REQ_ID_WIDTH-1:0]     win_id;
    logic                        win_valid;
    logic [REQ_ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]          grant_q, grant_d, done_q, done_d;
    logic [FLOAT_DATA_WIDTH-1:0] result_q, result_d, dataa_q, dataa_d, datab_q, datab_d;
    tag_t [ADD_LATENCY:0]        tag_q, tag_d;
    tag_t                        tag_out;
    state_t                      state_q, state_d;
    logic                        inflight;
    logic                        issue;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_ID_WIDTH(REQ_ID_WIDTH)) u_arb (
        .req(bus.req), .ptr(ptr_q), .win(win), .win_id(win_id), .valid(win_valid)
    );

    assign issue = clk_en && win_valid;
    assign tag_out = tag_q[ADD_LATENCY];

    always_comb begin
        grant_d = clk_en ? win : '0;
        ptr_d = !issue ? ptr_q : (win_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        dataa_d = issue ? bus.req_a[win_id*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH] : dataa_q;
        datab_d = issue ? bus.req_b[win_id*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH] : datab_q;
        tag_d = tag_q;
        if (clk_en) begin
            tag_d[0] = {win_valid, TAG_ID_W'(win_id)};
            for (int k = 1; k <= ADD_LATENCY; k++) tag_d[k] = tag_q[k-1];
        end
        done_d = (clk_en && tag_out.valid) ? NUM_REQ'(1) << tag_out.id : '0;
        result_d = (clk_en && tag_out.valid) ? add_result : result_q;
    end

    // work remains in flight after this edge if a grant is made or an unretired tag shifts along
    always_comb begin
        inflight = win_valid;
        for (int k = 0; k < ADD_LATENCY; k++) inflight = inflight | tag_q[k].valid;
        state_d = !clk_en ? state_q : inflight ? ACTIVE : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            grant_q <= '0;
            done_q <= '0;
            result_q <= '0;
            dataa_q <= '0;
            datab_q <= '0;
            tag_q <= '0;
            state_q <= IDLE;
        end else begin
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            done_q <= done_d;
            result_q <= result_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            tag_q <= tag_d;
            state_q <= state_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done = done_q;
    assign bus.result = result_q;
    assign bus.busy = (state_q == ACTIVE);
    assign add_aclr = ~rst;
    assign add_clk_en = clk_en;
    assign add_dataa = dataa_q;
    assign add_datab = datab_q;

`ifdef ADD_SCHED_PERF_EN
    logic [31:0] issue_q, issue_d, stall_q, stall_d;
    always_comb begin
        issue_d = issue_q + 32'(issue);
        stall_d = stall_q + 32'(clk_en && |(bus.req & ~win));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            issue_q <= issue_d;
            stall_q <= stall_d;
        end
    end
    assign issue_count = issue_q;
    assign stall_count = stall_q;
`else
    assign issue_count = '0;
    assign stall_count = '0;
`endif
endmodule
